flash_burst_rd_ctrl: RTL and testbench

- Parametrised successor to the single-word flash read controller.
- Reads bursts of consecutive words from an asynchronous parallel NOR flash.
- Timing is programmable by parameter: CE-to-OE setup, OE access time and inter-burst recovery.
- Sits between the weight/image loader and the flash pins. Presents a req/busy handshake upstream and a one-cycle rd_valid data strobe downstream.

---
 rtl/flash_burst_rd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_flash_burst_rd_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_burst_rd_ctrl.sv
// Burst read controller for an asynchronous parallel NOR flash.
// Programmable CE setup, OE access and recovery; every pin driven from a flop.
module flash_burst_rd_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4,
  parameter int T_CE   = 5,
  parameter int T_OE   = 5,
  parameter int T_GAP  = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic [DATA_W-1:0] flash_dq,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n
);

  // state   | meaning
  // IDLE    | pins released, waiting for req
  // SETUP   | CE low, waiting T_CE cycles before OE
  // READ    | CE and OE low, waiting T_OE cycles for data
  // NEXT    | word strobed on rd_valid; advance address or finish
  // RECOVER | pins released for T_GAP cycles before the next burst

  localparam int MAX_T = (T_CE > T_OE) ? ((T_CE > T_GAP) ? T_CE : T_GAP)
                                       : ((T_OE > T_GAP) ? T_OE : T_GAP);
  localparam int CNT_W = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] CE_TC  = CNT_W'(T_CE - 1);
  localparam logic [CNT_W-1:0] OE_TC  = CNT_W'(T_OE - 1);
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(T_GAP - 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_READ,
    S_NEXT,
    S_RECOVER
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] remaining;

  logic accept;
  logic capture;
  logic advance;
  logic cnt_clr;

  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (req) begin
          nxt    = S_SETUP;
          accept = 1'b1;
        end
      end
      S_SETUP: begin
        if (abort) begin
          nxt     = S_RECOVER;
          cnt_clr = 1'b1;
        end else if (cnt == CE_TC) begin
          nxt     = S_READ;
          cnt_clr = 1'b1;
        end
      end
      S_READ: begin
        if (abort) begin
          nxt     = S_RECOVER;
          cnt_clr = 1'b1;
        end else if (cnt == OE_TC) begin
          nxt     = S_NEXT;
          capture = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_NEXT: begin
        cnt_clr = 1'b1;
        // abort outranks continuing into the next word
        if (!abort && (remaining > LEN_ONE)) begin
          nxt     = S_READ;
          advance = 1'b1;
        end else begin
          nxt = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (cnt == GAP_TC) begin
          nxt     = S_IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        nxt     = S_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      remaining  <= '0;
      flash_addr <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      flash_ce_n <= 1'b1;
      flash_oe_n <= 1'b1;
      flash_we_n <= 1'b1;
    end else begin
      state <= nxt;
      cnt   <= cnt_clr ? '0 : cnt + 1'b1;

      if (accept) begin
        flash_addr <= start_addr;
        remaining  <= (burst_len == '0) ? LEN_ONE : burst_len;
      end else if (advance) begin
        flash_addr <= flash_addr + 1'b1;
        remaining  <= remaining - 1'b1;
      end

      if (capture) begin
        rd_data <= flash_dq;
      end
      rd_valid <= capture;
      rd_last  <= capture && (remaining == LEN_ONE);

      done <= (state == S_RECOVER) && (nxt == S_IDLE);
      busy <= (nxt != S_IDLE);

      // pins follow the upcoming state so they change with it, from flops
      flash_ce_n <= !((nxt == S_SETUP) || (nxt == S_READ) || (nxt == S_NEXT));
      flash_oe_n <= !((nxt == S_READ) || (nxt == S_NEXT));
      flash_we_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_burst_rd_ctrl.sv
// Self-checking bench for flash_burst_rd_ctrl: directed and random bursts
// compared cycle by cycle against a timing model derived from the burst rules.
module tb_flash_burst_rd_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
  localparam int T_CE   = 5;
  localparam int T_OE   = 5;
  localparam int T_GAP  = 2;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              req = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic              busy;
  logic              done;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic [ADDR_W-1:0] flash_addr;
  logic [DATA_W-1:0] flash_dq;
  logic              flash_ce_n;
  logic              flash_oe_n;
  logic              flash_we_n;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  flash_burst_rd_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .T_CE(T_CE), .T_OE(T_OE), .T_GAP(T_GAP)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .req(req),
    .abort(abort),
    .start_addr(start_addr),
    .burst_len(burst_len),
    .busy(busy),
    .done(done),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_last(rd_last),
    .flash_addr(flash_addr),
    .flash_dq(flash_dq),
    .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n)
  );

  function automatic logic [DATA_W-1:0] flash_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C ^ {a[3:0], 12'h000};
  endfunction

  // flash drives its array only while selected and output-enabled
  assign flash_dq = (!flash_ce_n && !flash_oe_n) ? flash_word(flash_addr) : 16'hDEAD;

  // One burst, checked every cycle. abort_at is the cycle (counted from the
  // accept edge) during which abort is held high; 0 means no abort.
  task automatic run_burst(input string name, input logic [ADDR_W-1:0] addr,
                           input logic [LEN_W-1:0] len, input int abort_at);
    int n, period, s_last, stop, end_c, k;
    logic e_busy, e_done, e_ce_n, e_oe_n, e_valid, e_last;
    logic [5:0] exp_v, got_v;
    logic [ADDR_W-1:0] exp_addr;
    n      = (len == 0) ? 1 : int'(len);
    period = T_OE + 1;
    s_last = T_CE + n * period;
    stop   = (abort_at > 0 && abort_at < s_last) ? abort_at : s_last;
    end_c  = stop + T_GAP;

    @(posedge clk);
    #1;
    req = 1'b1; start_addr = addr; burst_len = len; abort = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || flash_ce_n !== 1'b1) begin
      $display("FAIL %s pre-accept: busy=%b done=%b ce_n=%b required 0 0 1",
               name, busy, done, flash_ce_n);
    end else passed++;
    @(posedge clk);

    for (int c = 1; c <= end_c + 1; c++) begin
      @(negedge clk);
      e_busy  = (c <= end_c);
      e_done  = (c == end_c + 1);
      e_ce_n  = !(c <= stop);
      e_oe_n  = !(c > T_CE && c <= stop);
      e_valid = 1'b0;
      k       = 0;
      if (c > T_CE && ((c - T_CE) % period) == 0 && c <= stop) begin
        k       = (c - T_CE) / period - 1;
        e_valid = 1'b1;
      end
      e_last = e_valid && (k == n - 1);
      exp_v  = {e_busy, e_done, e_ce_n, e_oe_n, e_valid, e_last};
      got_v  = {busy, done, flash_ce_n, flash_oe_n, rd_valid, rd_last};
      total++;
      if (got_v !== exp_v)
        $display("FAIL %s cycle %0d busy/done/ce_n/oe_n/valid/last: got %b required %b",
                 name, c, got_v, exp_v);
      else passed++;
      if (e_valid) begin
        exp_addr = addr + ADDR_W'(k);
        total++;
        if (flash_addr !== exp_addr || rd_data !== flash_word(exp_addr))
          $display("FAIL %s word %0d: addr=%h data=%h required addr=%h data=%h",
                   name, k, flash_addr, rd_data, exp_addr, flash_word(exp_addr));
        else passed++;
      end
      // req and the request fields churn while busy; none of it may be taken
      req        = (c < end_c) ? 1'($urandom) : 1'b0;
      start_addr = ADDR_W'($urandom);
      burst_len  = LEN_W'($urandom);
      abort      = (c == abort_at);
    end
    abort = 1'b0;
    req   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, rd_valid, rd_last, flash_ce_n, flash_oe_n, flash_we_n} !== 7'b0000111 ||
        flash_addr !== '0 || rd_data !== '0)
      $display("FAIL reset: outs=%b addr=%h data=%h required 0000111 0000 0000",
               {busy, done, rd_valid, rd_last, flash_ce_n, flash_oe_n, flash_we_n},
               flash_addr, rd_data);
    else passed++;
    n_rst = 1'b1;
  endtask

  task automatic test_single();   run_burst("single", 16'h0100, 4'd1, 0); endtask
  task automatic test_burst4();   run_burst("burst4", 16'h0200, 4'd4, 0); endtask
  task automatic test_wrap();     run_burst("wrap",   16'hFFFE, 4'd3, 0); endtask
  task automatic test_len_zero(); run_burst("len0",   16'h1234, 4'd0, 0); endtask

  task automatic test_abort_back_to_back();
    // third READ cycle of word 2: word 1 strobes at 11, word 2 reads 12..16
    run_burst("abort", 16'h0300, 4'd4, 14);
    run_burst("after_abort", 16'h0310, 4'd2, 0);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    logic [LEN_W-1:0]  l;
    int ab;
    for (int i = 0; i < 20; i++) begin
      a  = ADDR_W'($urandom);
      l  = LEN_W'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, T_CE + 16 * (T_OE + 1))) : 0;
      run_burst("random", a, l, ab);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    req = 1'b1; start_addr = 16'h0400; burst_len = 4'd4;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    n_rst = 1'b0;
    #1;
    total++;
    if ({flash_ce_n, flash_oe_n, busy, rd_valid} !== 4'b1100 || flash_addr !== '0)
      $display("FAIL reset_mid immediate: ce_n/oe_n/busy/valid=%b addr=%h required 1100 0000",
               {flash_ce_n, flash_oe_n, busy, rd_valid}, flash_addr);
    else passed++;
    for (int c = 0; c < 12; c++) begin
      req = 1'($urandom);
      @(negedge clk);
      total++;
      if ({rd_valid, busy, flash_ce_n} !== 3'b001)
        $display("FAIL reset_mid hold cycle %0d: valid/busy/ce_n=%b required 001",
                 c, {rd_valid, busy, flash_ce_n});
      else passed++;
    end
    req   = 1'b0;
    n_rst = 1'b1;
    run_burst("after_reset", 16'h0500, 4'd2, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_wrap();
    test_len_zero();
    test_abort_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
